// File: rtl/uart_arb_pkg.sv
// Shared encodings and default sizing for the UART transmit arbiter.
package uart_arb_pkg;

  localparam int DEF_UART_DATA_SIZE = 8;
  localparam int DEF_NUM_REQ        = 2;
  localparam int DEF_TIMEOUT_TICKS  = 1000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the search starts at the index just
// above the previous owner and wraps to index 0.
module rr_arbiter import uart_arb_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant
);

  logic [NUM_REQ-1:0] upper_req;
  logic               found;

  // Lowest requester above last_grant wins; otherwise lowest requester overall.
  always_comb begin
    upper_req = '0;
    grant     = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      upper_req[i] = req[i] && (i > int'(last_grant));
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && upper_req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-granular arbiter feeding bytes from several requesters into one
// UART transmitter. An owner keeps the transmitter until its last byte has
// been shifted out, or until it stays silent for TIMEOUT_TICKS cycles.
module uart_tx_arbiter import uart_arb_pkg::*; #(
  parameter int UART_DATA_SIZE = DEF_UART_DATA_SIZE,
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int TIMEOUT_TICKS  = DEF_TIMEOUT_TICKS
) (
  input  logic                                i_clock,
  input  logic                                i_reset,
  input  logic [NUM_REQ-1:0]                  i_reqValid,
  input  logic [NUM_REQ*UART_DATA_SIZE-1:0]   i_reqData,
  input  logic [NUM_REQ-1:0]                  i_reqLast,
  output logic [NUM_REQ-1:0]                  o_reqReady,
  input  logic                                i_txReady,
  output logic [UART_DATA_SIZE-1:0]           o_txData,
  output logic                                o_txValid,
  output logic [NUM_REQ-1:0]                  o_grant,
  output logic                                o_busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_TICKS);

  arb_state_t                state_q, state_next;
  logic [NUM_REQ-1:0]        grant_q, grant_next;
  logic [IDX_W-1:0]          last_grant_q, last_grant_next;
  logic [CNT_W-1:0]          cnt_q, cnt_next, cnt_inc;
  logic [UART_DATA_SIZE-1:0] data_q, data_next, sel_data;
  logic                      last_q, last_next;
  logic [NUM_REQ-1:0]        rr_grant;
  logic [IDX_W-1:0]          owner_idx;
  logic                      owner_valid;
  logic                      owner_last;

  function automatic logic [IDX_W-1:0] onehot_idx(input logic [NUM_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req        (i_reqValid),
    .last_grant (last_grant_q),
    .grant      (rr_grant)
  );

  // Byte and last flag offered by the current owner (one-hot mux).
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) sel_data = i_reqData[i*UART_DATA_SIZE +: UART_DATA_SIZE];
    end
  end

  assign owner_valid = |(i_reqValid & grant_q);
  assign owner_last  = |(i_reqLast & grant_q);
  assign owner_idx   = onehot_idx(grant_q);
  // Saturating increment so a long-silent owner can never wrap the counter.
  assign cnt_inc     = (cnt_q == CNT_LIMIT) ? cnt_q : cnt_q + CNT_W'(1);

  // State register.
  always_ff @(posedge i_clock) begin
    if (i_reset) state_q <= ST_IDLE;
    else         state_q <= state_next;
  end

  // Next-state, grant bookkeeping and the combinational accept strobe.
  always_comb begin
    state_next      = state_q;
    grant_next      = grant_q;
    last_grant_next = last_grant_q;
    cnt_next        = cnt_q;
    data_next       = data_q;
    last_next       = last_q;
    o_reqReady      = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (|i_reqValid) begin
          grant_next = rr_grant;
          cnt_next   = '0;
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (i_txReady && owner_valid) begin
          o_reqReady = grant_q;
          data_next  = sel_data;
          last_next  = owner_last;
          cnt_next   = '0;
          state_next = ST_START;
        end else if (!owner_valid) begin
          cnt_next = cnt_inc;
          if (cnt_inc == CNT_LIMIT) begin
            grant_next      = '0;
            last_grant_next = owner_idx;
            state_next      = ST_IDLE;
          end
        end
      end
      ST_START: begin
        state_next = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (!i_txReady) state_next = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (i_txReady) begin
          if (last_q) begin
            last_grant_next = owner_idx;
            grant_next      = '0;
            state_next      = ST_IDLE;
          end else begin
            state_next = ST_LOAD;
          end
        end
      end
      default: begin
        grant_next = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

  // Owner, round-robin pointer, timeout counter and latched byte.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      cnt_q        <= '0;
      data_q       <= '0;
      last_q       <= 1'b0;
    end else begin
      grant_q      <= grant_next;
      last_grant_q <= last_grant_next;
      cnt_q        <= cnt_next;
      data_q       <= data_next;
      last_q       <= last_next;
    end
  end

  assign o_txValid = (state_q == ST_START);
  assign o_txData  = data_q;
  assign o_grant   = grant_q;
  assign o_busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: two requesters, short timeout, and a
// simple transmitter model that goes busy for three cycles after each start.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        i_reset;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  o_reqReady;
  logic        tx_rdy;
  logic [7:0]  o_txData;
  logic        o_txValid;
  logic [1:0]  o_grant;
  logic        o_busy;

  int checks = 0;
  int errors = 0;

  // Requester frame storage, owned by the stimulus block.
  logic [7:0] mem   [2][16];
  logic       lastm [2][16];
  int         start [2];
  int         len   [2];
  bit         en    [2];
  // Bytes accepted so far per requester, owned by the transmitter model.
  int         popped [2];

  logic [1:0] rdy_s = '0;
  logic       txv_s = 1'b0;
  int         busy_cnt;
  int         viol = 0;
  logic [9:0] txlog [$];

  uart_tx_arbiter #(
    .UART_DATA_SIZE (8),
    .NUM_REQ        (2),
    .TIMEOUT_TICKS  (8)
  ) dut (
    .i_clock    (clk),
    .i_reset    (i_reset),
    .i_reqValid (req_valid),
    .i_reqData  (req_data),
    .i_reqLast  (req_last),
    .o_reqReady (o_reqReady),
    .i_txReady  (tx_rdy),
    .o_txData   (o_txData),
    .o_txValid  (o_txValid),
    .o_grant    (o_grant),
    .o_busy     (o_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Requesters present the head of their frame while enabled.
  always_comb begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    for (int k = 0; k < 2; k++) begin
      if (en[k] && (popped[k] - start[k]) < len[k]) begin
        req_valid[k]       = 1'b1;
        req_data[k*8 +: 8] = mem[k][4'(popped[k] - start[k])];
        req_last[k]        = lastm[k][4'(popped[k] - start[k])];
      end
    end
  end

  // Mid-cycle sampling of DUT outputs, transmit log and ownership monitor.
  always @(negedge clk) begin
    rdy_s <= o_reqReady;
    txv_s <= o_txValid;
    if (o_txValid) txlog.push_back({o_grant, o_txData});
    if ((o_reqReady & ~o_grant) != 2'b00) viol++;
  end

  // Requester pop and transmitter busy model, applied just after the edge.
  initial begin
    tx_rdy   = 1'b1;
    busy_cnt = 0;
    popped   = '{0, 0};
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) if (rdy_s[k]) popped[k]++;
      if (txv_s) begin
        tx_rdy   = 1'b0;
        busy_cnt = 3;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) tx_rdy = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_frame(input int k, input int n,
                            input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic l0, input logic l1, input logic l2);
    mem[k][0] = b0; mem[k][1] = b1; mem[k][2] = b2;
    lastm[k][0] = l0; lastm[k][1] = l1; lastm[k][2] = l2;
    start[k] = popped[k];
    len[k]   = n;
  endtask

  function automatic bit all_consumed();
    return ((popped[0] - start[0]) >= len[0]) && ((popped[1] - start[1]) >= len[1]);
  endfunction

  task automatic wait_idle(input string tag, input int max_cyc);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge clk);
      if (!o_busy && all_consumed()) done = 1'b1;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic wait_tx(input string tag, input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (o_txValid) seen = 1'b1;
    end
    check({tag, "_start_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic check_log(input string tag, input int base, input int n,
                           input logic [9:0] e0, input logic [9:0] e1, input logic [9:0] e2);
    logic [9:0] e [3];
    logic [9:0] obs;
    e = '{e0, e1, e2};
    check({tag, "_count"}, 32'(txlog.size() - base), 32'(n));
    for (int i = 0; i < n; i++) begin
      obs = (base + i < txlog.size()) ? txlog[base + i] : 'x;
      check($sformatf("%s_byte%0d", tag, i), 32'(obs), 32'(e[i]));
    end
  endtask

  initial begin
    int base;
    int txv_cnt;
    en = '{0, 0};
    start = '{0, 0};
    len = '{0, 0};
    i_reset = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_txValid", 32'(o_txValid), 32'd0);
    check("rst_txData",  32'(o_txData),  32'd0);
    check("rst_reqReady", 32'(o_reqReady), 32'd0);
    check("rst_grant",   32'(o_grant),   32'd0);
    check("rst_busy",    32'(o_busy),    32'd0);
    i_reset = 1'b0;
    @(negedge clk);
    check("idle_no_req_busy", 32'(o_busy), 32'd0);

    // Single requester, 3-byte frame, with first-byte latency
    base = txlog.size();
    load_frame(0, 3, 8'h11, 8'h22, 8'h33, 1'b0, 1'b0, 1'b1);
    en[0] = 1'b1;
    @(negedge clk);
    check("lat_accept_ready", 32'(o_reqReady), 32'h1);
    check("lat_accept_grant", 32'(o_grant), 32'h1);
    check("lat_accept_busy",  32'(o_busy), 32'd1);
    @(negedge clk);
    check("lat_start_valid", 32'(o_txValid), 32'd1);
    check("lat_start_data",  32'(o_txData), 32'h11);
    @(negedge clk);
    check("start_one_cycle", 32'(o_txValid), 32'd0);
    check("grant_held", 32'(o_grant), 32'h1);
    wait_idle("single", 200);
    check_log("single", base, 3, {2'b01, 8'h11}, {2'b01, 8'h22}, {2'b01, 8'h33});
    check("txData_hold", 32'(o_txData), 32'h33);
    check("grant_released", 32'(o_grant), 32'd0);
    en = '{0, 0};

    // Simultaneous requests straight after reset: requester 0 first
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    base = txlog.size();
    load_frame(0, 2, 8'hA1, 8'hA2, 8'h00, 1'b0, 1'b1, 1'b0);
    load_frame(1, 1, 8'hB1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    en = '{1, 1};
    wait_idle("simul", 300);
    check_log("simul", base, 3, {2'b01, 8'hA1}, {2'b01, 8'hA2}, {2'b10, 8'hB1});
    en = '{0, 0};

    // Requester 1 waits while requester 0 has two single-byte frames
    base = txlog.size();
    load_frame(0, 2, 8'hC1, 8'hC2, 8'h00, 1'b1, 1'b1, 1'b0);
    load_frame(1, 1, 8'hD1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    en = '{1, 1};
    wait_idle("rr", 300);
    check_log("rr", base, 3, {2'b01, 8'hC1}, {2'b10, 8'hD1}, {2'b01, 8'hC2});
    en = '{0, 0};

    // Owner (requester 1) goes silent mid-frame: released after 8 LOAD cycles
    base = txlog.size();
    load_frame(1, 1, 8'hE0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    load_frame(0, 1, 8'hF0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    en = '{1, 1};
    wait_tx("tmo", 20);
    txv_cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (o_txValid) txv_cnt++;
    end
    check("tmo_grant_before", 32'(o_grant), 32'h2);
    @(negedge clk);
    if (o_txValid) txv_cnt++;
    check("tmo_grant_cleared", 32'(o_grant), 32'd0);
    check("tmo_idle", 32'(o_busy), 32'd0);
    check("tmo_no_emit", 32'(txv_cnt), 32'd0);
    @(negedge clk);
    check("tmo_other_granted", 32'(o_grant), 32'h1);
    @(negedge clk);
    check("tmo_other_start", 32'(o_txValid), 32'd1);
    check("tmo_other_data", 32'(o_txData), 32'hF0);
    wait_idle("tmo", 200);
    check_log("tmo", base, 2, {2'b10, 8'hE0}, {2'b01, 8'hF0}, 10'h0);
    en = '{0, 0};

    // Reset while waiting for the transmitter to go busy
    base = txlog.size();
    load_frame(1, 2, 8'h60, 8'h61, 8'h00, 1'b0, 1'b1, 1'b0);
    en[1] = 1'b1;
    wait_tx("rstmid", 20);
    @(negedge clk);
    check("rstmid_busy_before", 32'(o_busy), 32'd1);
    i_reset = 1'b1;
    @(negedge clk);
    check("rstmid_txValid", 32'(o_txValid), 32'd0);
    check("rstmid_txData",  32'(o_txData),  32'd0);
    check("rstmid_reqReady", 32'(o_reqReady), 32'd0);
    check("rstmid_grant",   32'(o_grant),   32'd0);
    check("rstmid_busy",    32'(o_busy),    32'd0);
    load_frame(0, 1, 8'h70, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    en[0] = 1'b1;
    i_reset = 1'b0;
    @(negedge clk);
    check("rstmid_first_grant", 32'(o_grant), 32'h1);
    wait_idle("rstmid", 300);
    check_log("rstmid", base, 3, {2'b10, 8'h60}, {2'b01, 8'h70}, {2'b10, 8'h61});

    check("ready_only_owner", 32'(viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
